// File: rtl/ecr_file_pkg.sv
// Shared types for the ECR file: speculation state codes and the issue-side,
// status and predictor-training records exchanged with the issue controller.
package ecr_file_pkg;

    localparam int NUM_ECRS = 2;
    localparam int ECR_W    = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
    localparam int PC_W     = 32;

    typedef enum logic [1:0] {
        ECR_BUSY = 2'b00,
        ECR_FREE = 2'b01,
        ECR_MISS = 2'b10
    } ecr_state_e;

    typedef struct packed {
        logic             wen;
        logic [ECR_W-1:0] addr;
        logic             do_reset;
        logic [1:0]       reset_data;
        logic             do_bpinfo;
        logic [PC_W-1:0]  bpinfo_pc;
        logic             bpinfo_pred_taken;
        logic             do_altpc;
        logic [PC_W-1:0]  altpc_pc;
    } ecr_reset_for_issue_t;

    typedef struct packed {
        logic                alloc_avail;
        logic [ECR_W-1:0]    alloc_id;
        logic                rollback_valid;
        logic [ECR_W-1:0]    rollback_id;
        logic [PC_W-1:0]     rollback_target_pc;
        logic [NUM_ECRS-1:0] in_use;
    } ecr_status_for_issue_t;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            taken;
    } bp_update_t;

    // An entry holds a live branch while it is pending or awaiting rollback.
    function automatic logic is_live(ecr_state_e s);
        return (s == ECR_BUSY) || (s == ECR_MISS);
    endfunction

endpackage

// File: rtl/ecr_age_matrix.sv
// Relative-age tracker for ECR entries: older[a][f] means f was live when a was
// allocated. Answers "oldest entry in a mask" and "entries younger than x".
module ecr_age_matrix
    import ecr_file_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic [ECR_W-1:0]    alloc_id,
    input  logic [NUM_ECRS-1:0] live,
    input  logic [NUM_ECRS-1:0] query_mask,
    input  logic [ECR_W-1:0]    query_id,
    output logic [ECR_W-1:0]    oldest_id,
    output logic [NUM_ECRS-1:0] younger
);

    logic [NUM_ECRS-1:0][NUM_ECRS-1:0] older;

    always_ff @(posedge clk) begin
        if (rst) begin
            older <= '0;
        end else if (alloc_en) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // bit below is computed from the pre-edge matrix regardless of loop order.
            for (int r = 0; r < NUM_ECRS; r++) begin
                for (int c = 0; c < NUM_ECRS; c++) begin
                    if (r == int'(alloc_id))
                        older[r][c] <= live[c] && (c != r);
                    else if (c == int'(alloc_id))
                        older[r][c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the loop leaves an output
        // unassigned (which would infer a latch); blocking '=' inside always_comb.
        oldest_id = '0;
        for (int e = NUM_ECRS - 1; e >= 0; e--) begin
            if (query_mask[e] && ((older[e] & query_mask) == '0))
                oldest_id = ECR_W'(e);
        end
    end

    always_comb begin
        younger = '0;
        for (int y = 0; y < NUM_ECRS; y++)
            younger[y] = older[y][query_id];
    end

endmodule

// File: rtl/ecr_file.sv
// ECR file: responder side of the issue <-> ECR protocol. Tracks per-branch
// speculation state, raises rollbacks and serializes predictor training updates.
module ecr_file
    import ecr_file_pkg::*;
#(
    parameter int NUM_SICS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  ecr_reset_for_issue_t           ecr_update,
    input  logic [NUM_SICS-1:0]            sic_resolve_valid,
    input  logic [NUM_SICS-1:0][1:0]       sic_resolve_ecr_id,
    input  logic [NUM_SICS-1:0]            sic_resolve_taken,
    input  logic [NUM_SICS-1:0]            sic_dep_valid,
    input  logic [NUM_SICS-1:0][1:0]       sic_dep_ecr_id,
    output ecr_status_for_issue_t          ecr_status,
    output logic [NUM_ECRS-1:0][1:0]       ecr_monitor,
    output bp_update_t                     bp_update
);

    ecr_state_e          state        [NUM_ECRS];
    logic [PC_W-1:0]     bpinfo_pc    [NUM_ECRS];
    logic [PC_W-1:0]     altpc        [NUM_ECRS];
    logic                pred_taken   [NUM_ECRS];
    logic                actual_taken [NUM_ECRS];
    logic [NUM_ECRS-1:0] bp_pending;

    logic [NUM_ECRS-1:0] in_use, live, miss, wr_hit, res_ok, res_taken, younger;
    logic [ECR_W-1:0]    alloc_id, rollback_id, bp_sel;
    logic                alloc_avail, bp_any, wr_alloc, wr_ack, squash;

    assign wr_alloc = ecr_update.wen && ecr_update.do_reset
                   && (ecr_state_e'(ecr_update.reset_data) == ECR_BUSY);
    assign wr_ack   = ecr_update.wen && ecr_update.do_reset
                   && (ecr_state_e'(ecr_update.reset_data) == ECR_FREE);

    always_comb begin
        in_use = '0;
        live   = '0;
        miss   = '0;
        wr_hit = '0;
        for (int e = 0; e < NUM_ECRS; e++) begin
            for (int s = 0; s < NUM_SICS; s++) begin
                if (sic_dep_valid[s] && (sic_dep_ecr_id[s] == 2'(e)))
                    in_use[e] = 1'b1;
            end
            live[e]   = is_live(state[e]);
            miss[e]   = (state[e] == ECR_MISS);
            wr_hit[e] = ecr_update.wen && (ecr_update.addr == ECR_W'(e));
        end
    end

    // Lowest-index selections: scan downwards so the last hit is the lowest.
    always_comb begin
        alloc_avail = 1'b0;
        alloc_id    = '0;
        bp_any      = 1'b0;
        bp_sel      = '0;
        for (int e = NUM_ECRS - 1; e >= 0; e--) begin
            if ((state[e] == ECR_FREE) && !in_use[e] && !bp_pending[e]) begin
                alloc_avail = 1'b1;
                alloc_id    = ECR_W'(e);
            end
            if (bp_pending[e]) begin
                bp_any = 1'b1;
                bp_sel = ECR_W'(e);
            end
        end
    end

    // Per-entry resolve: lowest SIC port wins; only pending entries not being
    // written by issue this cycle accept it.
    always_comb begin
        res_ok    = '0;
        res_taken = '0;
        for (int e = 0; e < NUM_ECRS; e++) begin
            for (int s = NUM_SICS - 1; s >= 0; s--) begin
                if (sic_resolve_valid[s] && (sic_resolve_ecr_id[s] == 2'(e))) begin
                    res_ok[e]    = 1'b1;
                    res_taken[e] = sic_resolve_taken[s];
                end
            end
            res_ok[e] = res_ok[e] && (state[e] == ECR_BUSY) && !wr_hit[e];
        end
    end

    ecr_age_matrix u_age (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (wr_alloc),
        .alloc_id   (ecr_update.addr),
        .live       (live),
        .query_mask (miss),
        .query_id   (rollback_id),
        .oldest_id  (rollback_id),
        .younger    (younger)
    );

    assign squash = wr_ack && (|miss) && (ecr_update.addr == rollback_id);

    always_comb begin
        ecr_status.alloc_avail        = alloc_avail;
        ecr_status.alloc_id           = alloc_id;
        ecr_status.rollback_valid     = |miss;
        ecr_status.rollback_id        = rollback_id;
        ecr_status.rollback_target_pc = altpc[rollback_id];
        ecr_status.in_use             = in_use;
        for (int e = 0; e < NUM_ECRS; e++)
            ecr_monitor[e] = state[e];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the per-entry PC storage is reset along with the state, since
            // issue may read altpc/bpinfo of an entry it never wrote.
            for (int e = 0; e < NUM_ECRS; e++) begin
                state[e]        <= ECR_FREE;
                bpinfo_pc[e]    <= '0;
                altpc[e]        <= '0;
                pred_taken[e]   <= 1'b0;
                actual_taken[e] <= 1'b0;
            end
            bp_pending <= '0;
            bp_update  <= '0;
        end else begin
            bp_update.valid <= bp_any;
            bp_update.pc    <= bp_any ? bpinfo_pc[bp_sel] : '0;
            bp_update.taken <= bp_any && actual_taken[bp_sel];

            for (int e = 0; e < NUM_ECRS; e++) begin
                if (res_ok[e]) begin
                    state[e]        <= (res_taken[e] == pred_taken[e]) ? ECR_FREE : ECR_MISS;
                    bp_pending[e]   <= 1'b1;
                    actual_taken[e] <= res_taken[e];
                end else if (bp_any && (bp_sel == ECR_W'(e))) begin
                    bp_pending[e] <= 1'b0;
                end

                // Wrong-path entries behind an acked rollback are freed untrained.
                if (squash && younger[e]) begin
                    state[e]      <= ECR_FREE;
                    bp_pending[e] <= 1'b0;
                end

                if (wr_hit[e]) begin
                    if (wr_alloc)
                        state[e] <= ECR_BUSY;
                    else if (wr_ack)
                        state[e] <= ECR_FREE;
                    if (ecr_update.do_bpinfo) begin
                        bpinfo_pc[e]  <= ecr_update.bpinfo_pc;
                        pred_taken[e] <= ecr_update.bpinfo_pred_taken;
                    end
                    if (ecr_update.do_altpc)
                        altpc[e] <= ecr_update.altpc_pc;
                end
            end
        end
    end

endmodule
